mem_wb_stage: RTL

//  MEM->WB pipeline stage of the RISC-V core. Accepts one retired EX/MEM op per handshake.
//  For loads, waits on the data-memory response, then aligns and sign/zero-extends it.

---
 rtl/mem_wb_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB stage: load wait, align/extend, registered write-back candidates
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic            flush,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic [REGW-1:0] wb_rd,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_pc_plus4,
  output logic            wb_exc,
  output logic [1:0]      wb_exc_code
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] cap_alu, cap_pc;
  logic [REGW-1:0] cap_rd;
  logic            cap_rw, cap_dead;
  logic [1:0]      cap_sel;
  logic [2:0]      cap_f3;
  logic [CW-1:0]   cnt;

  logic            accept, illegal, misaligned, capture, fire, fire_exc;
  logic [1:0]      fire_code;
  logic [XLEN-1:0] fire_ldata, load_ext, byte_lane, half_lane;
  logic            src_wait;

  assign accept   = in_valid & in_ready;
  assign src_wait = (state == WAIT_LOAD);

  always_comb begin
    illegal = 1'b1;
    case (in_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
    misaligned = ((in_funct3[1:0] == 2'b01) & in_alu_result[0]) |
                 ((in_funct3 == 3'b010) & (in_alu_result[1:0] != 2'b00));
  end

  // Response is a full aligned word; pick the addressed lane before extending.
  always_comb begin
    byte_lane = dmem_rdata >> {cap_alu[1:0], 3'b000};
    half_lane = dmem_rdata >> {cap_alu[1], 4'b0000};
    case (cap_f3)
      3'b000:  load_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane[7:0]};
      3'b001:  load_ext = {{(XLEN-16){half_lane[15]}}, half_lane[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_lane[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_lane[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    capture    = 1'b0;
    fire       = 1'b0;
    fire_exc   = 1'b0;
    fire_code  = 2'b00;
    fire_ldata = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          if (in_is_load && !illegal && !misaligned) begin
            capture   = 1'b1;
            state_nxt = WAIT_LOAD;
          end else begin
            fire      = ~flush;
            fire_exc  = in_is_load;
            if (in_is_load) fire_code = illegal ? 2'b10 : 2'b01;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          fire       = ~cap_dead & ~flush;
          fire_ldata = load_ext;
          state_nxt  = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fire      = ~cap_dead & ~flush;
          fire_exc  = 1'b1;
          fire_code = 2'b11;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_alu       <= '0;
      cap_pc        <= '0;
      cap_rd        <= '0;
      cap_rw        <= 1'b0;
      cap_sel       <= 2'b00;
      cap_f3        <= 3'b000;
      cap_dead      <= 1'b0;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_rd         <= '0;
      wb_sel        <= 2'b00;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_pc_plus4   <= '0;
      wb_exc        <= 1'b0;
      wb_exc_code   <= 2'b00;
    end else begin
      cnt <= (src_wait && !dmem_rvalid) ? cnt + CW'(1) : '0;
      if (capture) begin
        cap_alu  <= in_alu_result;
        cap_pc   <= in_pc_plus4;
        cap_rd   <= in_rd;
        cap_rw   <= in_regwrite;
        cap_sel  <= in_wb_sel;
        cap_f3   <= in_funct3;
        cap_dead <= flush;
      end else if (src_wait && flush) begin
        cap_dead <= 1'b1;
      end
      wb_valid    <= fire;
      wb_regwrite <= fire & ~fire_exc & (src_wait ? cap_rw : in_regwrite);
      wb_exc      <= fire & fire_exc;
      // Candidates hold their last values across idle cycles and squashed ops.
      if (fire) begin
        wb_rd         <= src_wait ? cap_rd  : in_rd;
        wb_sel        <= src_wait ? cap_sel : in_wb_sel;
        wb_alu_result <= src_wait ? cap_alu : in_alu_result;
        wb_pc_plus4   <= src_wait ? cap_pc  : in_pc_plus4;
        wb_load_data  <= fire_ldata;
        wb_exc_code   <= fire_code;
      end
    end
  end
endmodule
